// File: rtl/sprf_ptr_unit_pkg.sv
// Shared definitions for the special-purpose pointer register file.
// Holds the default address width, the decoder opcode constants and the
// FSM state encoding. Has no ports.
`ifndef DMEMADDRW
`define DMEMADDRW 10
`endif

package sprf_ptr_unit_pkg;

   localparam int PTR_ADDR_W = `DMEMADDRW;

   localparam logic [2:0] PTR_OP_NOP    = 3'd0;
   localparam logic [2:0] PTR_OP_LDBASE = 3'd1;
   localparam logic [2:0] PTR_OP_LDLIM  = 3'd2;
   localparam logic [2:0] PTR_OP_LDSTR  = 3'd3;
   localparam logic [2:0] PTR_OP_RD     = 3'd4;
   localparam logic [2:0] PTR_OP_RDINC  = 3'd5;
   localparam logic [2:0] PTR_OP_BURST  = 3'd6;

   typedef enum logic {
      PTR_IDLE  = 1'b0,
      PTR_BURST = 1'b1
   } ptr_state_e;

endpackage

// File: rtl/sprf_ptr_unit_if.sv
// Decoder-to-pointer-unit request bus and pointer-unit-to-wrapper response.
// Signals:
//   ipt_dec_to_ptr_op/sel/imm : opcode, pointer select, immediate (decoder)
//   opt_ptr_to_wrp_addr/vld   : indirect address and its valid
//   opt_ptr_wrap              : successor of this address wrapped
//   opt_ptr_busy / opt_ptr_rej: burst in progress / op dropped while busy
// master = decoder side, slave = pointer unit.
interface sprf_ptr_unit_if #(
   parameter int ADDR_W = 10,
   parameter int SEL_W  = 2
);
   logic [2:0]        ipt_dec_to_ptr_op;
   logic [SEL_W-1:0]  ipt_dec_to_ptr_sel;
   logic [ADDR_W-1:0] ipt_dec_to_ptr_imm;
   logic [ADDR_W-1:0] opt_ptr_to_wrp_addr;
   logic              opt_ptr_to_wrp_vld;
   logic              opt_ptr_wrap;
   logic              opt_ptr_busy;
   logic              opt_ptr_rej;

   modport master (
      output ipt_dec_to_ptr_op, ipt_dec_to_ptr_sel, ipt_dec_to_ptr_imm,
      input  opt_ptr_to_wrp_addr, opt_ptr_to_wrp_vld, opt_ptr_wrap,
             opt_ptr_busy, opt_ptr_rej
   );

   modport slave (
      input  ipt_dec_to_ptr_op, ipt_dec_to_ptr_sel, ipt_dec_to_ptr_imm,
      output opt_ptr_to_wrp_addr, opt_ptr_to_wrp_vld, opt_ptr_wrap,
             opt_ptr_busy, opt_ptr_rej
   );
endinterface

// File: rtl/sprf_ptr_unit_ptr_modinc.sv
// Combinational modulo post-increment for one pointer.
// Ports:
//   cur_i, stride_i, base_i, limit_i : pointer state of the active pointer
//   next_o : successor of cur_i
//   wrap_o : successor went past limit_i and was folded back onto base_i
module ptr_modinc #(
   parameter int ADDR_W = 10
) (
   input  logic [ADDR_W-1:0] cur_i,
   input  logic [ADDR_W-1:0] stride_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] limit_i,
   output logic [ADDR_W-1:0] next_o,
   output logic              wrap_o
);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   logic [ADDR_W:0]   sum;
   logic [ADDR_W-1:0] excess;

   // Carry bit kept so cur+stride beyond the address range still compares
   // as larger than any limit. The overshoot only needs its low bits since
   // the folded result is truncated anyway.
   assign sum    = {1'b0, cur_i} + {1'b0, stride_i};
   assign wrap_o = (sum > {1'b0, limit_i});
   assign excess = sum[ADDR_W-1:0] - limit_i - ONE;
   assign next_o = wrap_o ? (base_i + excess) : sum[ADDR_W-1:0];
endmodule

// File: rtl/sprf_ptr_unit.sv
// Special-purpose pointer register file producing indirect data-RAM
// addresses. Each pointer has base, limit, stride and a current value;
// RDINC and burst mode post-increment with modulo wrap onto base.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   t_cs       : global advance enable; low freezes every register
//   bus        : slave side of sprf_ptr_unit_if (decoder ops in,
//                address/valid/wrap/busy/reject out, all registered)
module sprf_ptr_unit
   import sprf_ptr_unit_pkg::*;
#(
   parameter int ADDR_W = PTR_ADDR_W,
   parameter int NPTR   = 4,
   parameter int CNT_W  = 8,
   parameter int SEL_W  = $clog2(NPTR)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           t_cs,
   sprf_ptr_unit_if.slave bus
);
   logic [NPTR-1:0][ADDR_W-1:0] base_q, cur_q, lim_q, str_q;
   ptr_state_e                  state_q;
   logic [SEL_W-1:0]            bsel_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [ADDR_W-1:0]           addr_q;
   logic                        vld_q, wrap_q, busy_q, rej_q;

   logic [2:0]        op;
   logic [SEL_W-1:0]  sel;
   logic [ADDR_W-1:0] imm;
   logic [SEL_W-1:0]  idx;
   logic [ADDR_W-1:0] mi_next;
   logic              mi_wrap;

   assign op  = bus.ipt_dec_to_ptr_op;
   assign sel = bus.ipt_dec_to_ptr_sel;
   assign imm = bus.ipt_dec_to_ptr_imm;

   // Only one pointer advances per cycle: the burst pointer while bursting,
   // otherwise whatever the decoder selects.
   assign idx = (state_q == PTR_BURST) ? bsel_q : sel;

   ptr_modinc #(.ADDR_W(ADDR_W)) u_modinc (
      .cur_i    (cur_q[idx]),
      .stride_i (str_q[idx]),
      .base_i   (base_q[idx]),
      .limit_i  (lim_q[idx]),
      .next_o   (mi_next),
      .wrap_o   (mi_wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NPTR; i++) begin
            base_q[i] <= '0;
            cur_q[i]  <= '0;
            lim_q[i]  <= '1;
            str_q[i]  <= ADDR_W'(1);
         end
         state_q <= PTR_IDLE;
         bsel_q  <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         vld_q   <= 1'b0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
         rej_q   <= 1'b0;
      end else if (t_cs) begin
         vld_q  <= 1'b0;
         wrap_q <= 1'b0;
         rej_q  <= 1'b0;
         case (state_q)
            PTR_IDLE: begin
               case (op)
                  PTR_OP_LDBASE: begin
                     base_q[sel] <= imm;
                     cur_q[sel]  <= imm;
                  end
                  PTR_OP_LDLIM: lim_q[sel] <= imm;
                  PTR_OP_LDSTR: str_q[sel] <= imm;
                  PTR_OP_RD: begin
                     addr_q <= cur_q[sel];
                     vld_q  <= 1'b1;
                  end
                  PTR_OP_RDINC: begin
                     addr_q     <= cur_q[sel];
                     vld_q      <= 1'b1;
                     wrap_q     <= mi_wrap;
                     cur_q[sel] <= mi_next;
                  end
                  PTR_OP_BURST: begin
                     // A zero count is a NOP; first address appears one
                     // edge after the accept, from the BURST state.
                     if (imm[CNT_W-1:0] != '0) begin
                        bsel_q  <= sel;
                        cnt_q   <= imm[CNT_W-1:0];
                        state_q <= PTR_BURST;
                        busy_q  <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            PTR_BURST: begin
               addr_q        <= cur_q[bsel_q];
               vld_q         <= 1'b1;
               wrap_q        <= mi_wrap;
               cur_q[bsel_q] <= mi_next;
               cnt_q         <= cnt_q - CNT_W'(1);
               rej_q         <= (op != PTR_OP_NOP);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= PTR_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= PTR_IDLE;
         endcase
      end
   end

   assign bus.opt_ptr_to_wrp_addr = addr_q;
   assign bus.opt_ptr_to_wrp_vld  = vld_q;
   assign bus.opt_ptr_wrap        = wrap_q;
   assign bus.opt_ptr_busy        = busy_q;
   assign bus.opt_ptr_rej         = rej_q;
endmodule

// File: tb/tb_sprf_ptr_unit.sv
// Scoreboard bench for sprf_ptr_unit: stimulus pushes expected
// {wrap,addr} beats, a negedge monitor pops one per fresh valid output.
module tb_sprf_ptr_unit;
   import sprf_ptr_unit_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic t_cs = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic adv = 1'b0;
   logic [10:0] expq[$];

   sprf_ptr_unit_if #(.ADDR_W(10), .SEL_W(2)) bus ();

   sprf_ptr_unit #(.ADDR_W(10), .NPTR(4), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .t_cs  (t_cs),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Outputs are fresh only after an enabled, non-reset edge.
   always @(posedge clk) adv <= t_cs & ~reset;

   always @(negedge clk) begin
      if (adv && bus.opt_ptr_to_wrp_vld) begin
         logic [10:0] e;
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_vld addr=%h (no beat expected)", bus.opt_ptr_to_wrp_addr);
         end else begin
            e = expq.pop_front();
            if ({bus.opt_ptr_wrap, bus.opt_ptr_to_wrp_addr} !== e) begin
               errors++;
               $display("FAIL beat got wrap=%0b addr=%h want wrap=%0b addr=%h",
                        bus.opt_ptr_wrap, bus.opt_ptr_to_wrp_addr, e[10], e[9:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [2:0] op, input logic [1:0] sel, input logic [9:0] imm);
      bus.ipt_dec_to_ptr_op  = op;
      bus.ipt_dec_to_ptr_sel = sel;
      bus.ipt_dec_to_ptr_imm = imm;
      @(posedge clk);
      #1;
      bus.ipt_dec_to_ptr_op  = PTR_OP_NOP;
      bus.ipt_dec_to_ptr_sel = '0;
      bus.ipt_dec_to_ptr_imm = '0;
   endtask

   task automatic push(input logic w, input logic [9:0] a);
      expq.push_back({w, a});
   endtask

   initial begin
      int n;
      bus.ipt_dec_to_ptr_op  = PTR_OP_NOP;
      bus.ipt_dec_to_ptr_sel = '0;
      bus.ipt_dec_to_ptr_imm = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld",  int'(bus.opt_ptr_to_wrp_vld), 0);
      chk("rst_busy", int'(bus.opt_ptr_busy), 0);
      chk("rst_rej",  int'(bus.opt_ptr_rej), 0);
      chk("rst_wrap", int'(bus.opt_ptr_wrap), 0);
      chk("rst_addr", int'(bus.opt_ptr_to_wrp_addr), 0);
      reset = 1'b0;

      // RD of a fresh pointer
      push(0, 10'h000);
      step(PTR_OP_RD, 0, 0);

      // pointer 1: stride-1 ring 0x100..0x103
      step(PTR_OP_LDBASE, 1, 10'h100);
      step(PTR_OP_LDLIM,  1, 10'h103);
      step(PTR_OP_LDSTR,  1, 10'h001);
      push(0, 10'h100); push(0, 10'h101); push(0, 10'h102);
      push(1, 10'h103); push(0, 10'h100);
      repeat (5) step(PTR_OP_RDINC, 1, 0);

      // pointer 2: burst of 4, stride 6, wraps at top of memory
      step(PTR_OP_LDBASE, 2, 10'h3F0);
      step(PTR_OP_LDLIM,  2, 10'h3FF);
      step(PTR_OP_LDSTR,  2, 10'h006);
      push(0, 10'h3F0); push(0, 10'h3F6); push(1, 10'h3FC); push(0, 10'h3F2);
      step(PTR_OP_BURST, 2, 10'h004);
      chk("burst_accept_busy", int'(bus.opt_ptr_busy), 1);
      chk("burst_accept_vld",  int'(bus.opt_ptr_to_wrp_vld), 0);
      step(PTR_OP_LDBASE, 2, 10'h055);
      chk("busy_rej", int'(bus.opt_ptr_rej), 1);
      chk("busy_b1",  int'(bus.opt_ptr_busy), 1);
      step(PTR_OP_NOP, 0, 0);
      chk("nop_no_rej", int'(bus.opt_ptr_rej), 0);
      step(PTR_OP_NOP, 0, 0);
      chk("busy_b3", int'(bus.opt_ptr_busy), 1);
      step(PTR_OP_NOP, 0, 0);
      chk("busy_done", int'(bus.opt_ptr_busy), 0);
      // rejected LDBASE left pointer 2 alone: next(0x3F2) = 0x3F8
      push(0, 10'h3F8);
      step(PTR_OP_RD, 2, 0);

      // zero low count bits: NOP
      step(PTR_OP_BURST, 0, 10'h100);
      chk("burst0_busy", int'(bus.opt_ptr_busy), 0);
      chk("burst0_vld",  int'(bus.opt_ptr_to_wrp_vld), 0);

      // pointer 3: burst of 5 stride 2, frozen for 3 cycles mid-way
      step(PTR_OP_LDSTR, 3, 10'h002);
      push(0, 10'h000); push(0, 10'h002); push(0, 10'h004);
      push(0, 10'h006); push(0, 10'h008);
      step(PTR_OP_BURST, 3, 10'h005);
      step(PTR_OP_NOP, 0, 0);
      step(PTR_OP_NOP, 0, 0);
      t_cs = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(PTR_OP_NOP, 0, 0);
         chk("frz_addr", int'(bus.opt_ptr_to_wrp_addr), 'h002);
         chk("frz_vld",  int'(bus.opt_ptr_to_wrp_vld), 1);
         chk("frz_busy", int'(bus.opt_ptr_busy), 1);
      end
      t_cs = 1'b1;
      n = 0;
      do begin
         step(PTR_OP_NOP, 0, 0);
         n++;
      end while (bus.opt_ptr_busy && n < 10);
      chk("frz_remaining", n, 3);

      // reset mid-burst on pointer 2 (limit 0x3FF, stride 6)
      step(PTR_OP_LDBASE, 2, 10'h3F0);
      push(0, 10'h3F0); push(0, 10'h3F6);
      step(PTR_OP_BURST, 2, 10'h006);
      step(PTR_OP_NOP, 0, 0);
      step(PTR_OP_NOP, 0, 0);
      reset = 1'b1;
      step(PTR_OP_NOP, 0, 0);
      chk("midrst_busy", int'(bus.opt_ptr_busy), 0);
      chk("midrst_vld",  int'(bus.opt_ptr_to_wrp_vld), 0);
      reset = 1'b0;
      push(0, 10'h000);
      step(PTR_OP_RD, 2, 0);
      // limit back to 0x3FF, stride 1: 0x3FF+1 folds to base
      step(PTR_OP_LDBASE, 2, 10'h3FE);
      push(0, 10'h3FE); push(1, 10'h3FF); push(0, 10'h3FE);
      repeat (3) step(PTR_OP_RDINC, 2, 0);

      // stride 0 keeps the pointer fixed
      step(PTR_OP_LDSTR, 0, 10'h000);
      push(0, 10'h000); push(0, 10'h000);
      repeat (2) step(PTR_OP_RDINC, 0, 0);

      repeat (3) step(PTR_OP_NOP, 0, 0);
      chk("scoreboard_empty", expq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
